sump_cmd_decoder: RTL and testbench

//  Assembles SUMP host commands from the UART RXD byte stream and presents them to the

---
 rtl/sump_pkg.sv | 17 +
 rtl/sump_cmd_decoder.sv | 117 +++++++++++
 tb/tb_sump_cmd_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sump_pkg.sv
// Shared SUMP protocol definitions: decoder state encoding and well-known opcodes.
package sump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        EMIT = 2'd2
    } cmd_dec_state_t;

    localparam logic [7:0] SUMP_RESET    = 8'h00;
    localparam logic [7:0] SUMP_RUN      = 8'h01;
    localparam logic [7:0] SUMP_ID       = 8'h02;
    localparam logic [7:0] SUMP_XON      = 8'h11;
    localparam logic [7:0] SUMP_XOFF     = 8'h13;
    localparam int         SUMP_LONG_BIT = 7;

endpackage

// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP short/long commands from the UART byte stream into a one-cycle
// command strobe, discarding partial long commands after an inter-byte timeout.
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int TMO = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        str_rxd_tvalid,
    input  logic [7:0]  str_rxd_tdata,
    output logic        str_rxd_tready,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        sts_busy,
    output logic        err_timeout
);

    localparam int             TW       = $clog2(TMO);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

    cmd_dec_state_t state_reg;
    logic [1:0]     cnt_reg;
    logic [TW-1:0]  tmo_reg;
    logic [7:0]     code_reg;
    logic [31:0]    data_reg;
    logic           tready_reg;
    logic [7:0]     cmd_code_reg;
    logic [31:0]    cmd_data_reg;
    logic           cmd_valid_reg;
    logic           busy_reg;
    logic           err_reg;
    logic           accept;

    assign accept = str_rxd_tvalid & tready_reg;

    // code_reg/data_reg assemble the command privately; the cmd_* outputs only
    // change when a command is emitted, so a timed-out command never leaks out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            tmo_reg       <= '0;
            code_reg      <= 8'h00;
            data_reg      <= 32'h0;
            tready_reg    <= 1'b0;
            cmd_code_reg  <= 8'h00;
            cmd_data_reg  <= 32'h0;
            cmd_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            cmd_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tready_reg <= 1'b1;
                    if (accept) begin
                        code_reg <= str_rxd_tdata;
                        data_reg <= 32'h0;
                        if (!str_rxd_tdata[SUMP_LONG_BIT]) begin
                            state_reg     <= EMIT;
                            cmd_code_reg  <= str_rxd_tdata;
                            cmd_data_reg  <= 32'h0;
                            cmd_valid_reg <= 1'b1;
                            tready_reg    <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                            cnt_reg   <= 2'd0;
                            tmo_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        data_reg[{cnt_reg, 3'b000} +: 8] <= str_rxd_tdata;
                        cnt_reg <= cnt_reg + 2'd1;
                        tmo_reg <= '0;
                        if (cnt_reg == 2'd3) begin
                            state_reg     <= EMIT;
                            cmd_code_reg  <= code_reg;
                            cmd_data_reg  <= {str_rxd_tdata, data_reg[23:0]};
                            cmd_valid_reg <= 1'b1;
                            tready_reg    <= 1'b0;
                            busy_reg      <= 1'b0;
                        end
                    end else if (tmo_reg == TMO_LAST) begin
                        state_reg <= IDLE;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                EMIT: begin
                    state_reg  <= IDLE;
                    tready_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= IDLE;
                    tready_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign str_rxd_tready = tready_reg;
    assign cmd_code       = cmd_code_reg;
    assign cmd_data       = cmd_data_reg;
    assign cmd_valid      = cmd_valid_reg;
    assign sts_busy       = busy_reg;
    assign err_timeout    = err_reg;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: vector table, hand-written timeout/reset sequences,
// and randomized traffic against a queue-based protocol model.
module tb_sump_cmd_decoder;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tvalid = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        tready;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        sts_busy;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    sump_cmd_decoder #(.TMO(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .str_rxd_tvalid (tvalid),
        .str_rxd_tdata  (tdata),
        .str_rxd_tready (tready),
        .cmd_code       (cmd_code),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .sts_busy       (sts_busy),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    // Packed observation: {tready, cmd_valid, sts_busy, err_timeout, cmd_code, cmd_data}
    function automatic logic [43:0] o(bit rdy, bit vld, bit busy, bit err,
                                      logic [7:0] c, logic [31:0] d);
        return {rdy, vld, busy, err, c, d};
    endfunction

    task automatic chk(input string nm, input logic [43:0] exp);
        logic [43:0] act;
        act = {tready, cmd_valid, sts_busy, err_timeout, cmd_code, cmd_data};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rdy=%b vld=%b busy=%b err=%b code=%h data=%h, want rdy=%b vld=%b busy=%b err=%b code=%h data=%h",
                     nm, act[43], act[42], act[41], act[40], act[39:32], act[31:0],
                     exp[43], exp[42], exp[41], exp[40], exp[39:32], exp[31:0]);
        end
    endtask

    // Inputs are driven 1 time unit after an edge; outputs are sampled at the same point.
    task automatic step(input bit v, input logic [7:0] b);
        tvalid = v;
        tdata  = b;
        @(posedge clk);
        #1;
    endtask

    // Protocol-level reference: bytes of a pending long command sit in a queue.
    logic [7:0]  m_q[$];
    int          m_gap;
    bit          m_rdy, m_vld, m_err;
    logic [7:0]  m_code;
    logic [31:0] m_data;

    task automatic model_reset();
        m_q.delete();
        m_gap  = 0;
        m_rdy  = 0;
        m_vld  = 0;
        m_err  = 0;
        m_code = 8'h00;
        m_data = 32'h0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        bit nv, ne;
        nv = 0;
        ne = 0;
        if (v && m_rdy) begin
            if (m_q.size() == 0 && !b[7]) begin
                nv = 1; m_code = b; m_data = 32'h0;
            end else begin
                m_q.push_back(b);
                m_gap = 0;
                if (m_q.size() == 5) begin
                    nv = 1;
                    m_code = m_q[0];
                    m_data = {m_q[4], m_q[3], m_q[2], m_q[1]};
                    m_q.delete();
                end
            end
        end else if (m_q.size() > 0) begin
            if (m_gap == TMO - 1) begin
                ne = 1;
                m_q.delete();
            end else begin
                m_gap++;
            end
        end
        m_vld = nv;
        m_err = ne;
        m_rdy = !nv;
    endtask

    function automatic logic [43:0] m_exp();
        return o(m_rdy, m_vld, m_q.size() != 0, m_err, m_code, m_data);
    endfunction

    typedef struct {
        bit          tv;
        logic [7:0]  td;
        logic [43:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int pv;
        bit v;
        logic [7:0] b;

        // Short command, long command, then back-to-back stream with tvalid held high.
        tbl.push_back('{1'b1, 8'h01, o(0, 1, 0, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b0, 8'h00, o(1, 0, 0, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b1, 8'hC0, o(1, 0, 1, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b1, 8'h78, o(1, 0, 1, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b1, 8'h56, o(1, 0, 1, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b1, 8'h34, o(1, 0, 1, 0, 8'h01, 32'h0)});
        tbl.push_back('{1'b1, 8'h12, o(0, 1, 0, 0, 8'hC0, 32'h12345678)});
        tbl.push_back('{1'b1, 8'h00, o(1, 0, 0, 0, 8'hC0, 32'h12345678)});
        for (int k = 0; k < 5; k++) begin
            tbl.push_back('{1'b1, 8'h00, o(0, 1, 0, 0, 8'h00, 32'h0)});
            tbl.push_back('{1'b1, (k == 4) ? 8'h80 : 8'h00, o(1, 0, 0, 0, 8'h00, 32'h0)});
        end
        tbl.push_back('{1'b1, 8'h80, o(1, 0, 1, 0, 8'h00, 32'h0)});
        tbl.push_back('{1'b1, 8'h01, o(1, 0, 1, 0, 8'h00, 32'h0)});
        tbl.push_back('{1'b1, 8'h00, o(1, 0, 1, 0, 8'h00, 32'h0)});
        tbl.push_back('{1'b1, 8'h00, o(1, 0, 1, 0, 8'h00, 32'h0)});
        tbl.push_back('{1'b1, 8'h00, o(0, 1, 0, 0, 8'h80, 32'h00000001)});
        tbl.push_back('{1'b0, 8'h00, o(1, 0, 0, 0, 8'h80, 32'h00000001)});

        // Reset state and release.
        #1;
        chk("reset_async", o(0, 0, 0, 0, 8'h00, 32'h0));
        step(0, 8'h00);
        step(0, 8'h00);
        chk("reset_held", o(0, 0, 0, 0, 8'h00, 32'h0));
        rst = 1'b1;
        step(0, 8'h00);
        chk("release", o(1, 0, 0, 0, 8'h00, 32'h0));

        foreach (tbl[i]) begin
            step(tbl[i].tv, tbl[i].td);
            $display("vec %0d: tv=%b td=%h -> vld=%b code=%h data=%h", i, tbl[i].tv, tbl[i].td,
                     cmd_valid, cmd_code, cmd_data);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Partial long command times out; outputs keep the last emitted command.
        step(1, 8'h81); chk("tmo_op", o(1, 0, 1, 0, 8'h80, 32'h1));
        step(1, 8'hAA); chk("tmo_b0", o(1, 0, 1, 0, 8'h80, 32'h1));
        step(1, 8'hBB); chk("tmo_b1", o(1, 0, 1, 0, 8'h80, 32'h1));
        for (int k = 0; k < TMO - 1; k++) begin
            step(0, 8'h00);
            chk($sformatf("tmo_wait%0d", k), o(1, 0, 1, 0, 8'h80, 32'h1));
        end
        step(0, 8'h00); chk("tmo_pulse", o(1, 0, 0, 1, 8'h80, 32'h1));
        step(0, 8'h00); chk("tmo_clear", o(1, 0, 0, 0, 8'h80, 32'h1));
        step(1, 8'h02); chk("tmo_next", o(0, 1, 0, 0, 8'h02, 32'h0));
        step(0, 8'h00);
        $display("seq timeout: done");

        // Byte arriving exactly at the last count is accepted.
        step(1, 8'h83); chk("edge_op", o(1, 0, 1, 0, 8'h02, 32'h0));
        step(1, 8'h11);
        step(1, 8'h22);
        for (int k = 0; k < TMO - 1; k++) begin
            step(0, 8'h00);
            chk($sformatf("edge_wait%0d", k), o(1, 0, 1, 0, 8'h02, 32'h0));
        end
        step(1, 8'h33); chk("edge_accept", o(1, 0, 1, 0, 8'h02, 32'h0));
        step(1, 8'h44); chk("edge_emit", o(0, 1, 0, 0, 8'h83, 32'h44332211));
        step(0, 8'h00);
        $display("seq edge: done");

        // Reset in the middle of a long command.
        step(1, 8'h82);
        step(1, 8'hA5);
        step(1, 8'h5A);
        tvalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid", o(0, 0, 0, 0, 8'h00, 32'h0));
        step(0, 8'h00);
        step(0, 8'h00);
        chk("rst_mid_held", o(0, 0, 0, 0, 8'h00, 32'h0));
        rst = 1'b1;
        step(0, 8'h00); chk("rst_release", o(1, 0, 0, 0, 8'h00, 32'h0));
        step(1, 8'h01); chk("rst_post", o(0, 1, 0, 0, 8'h01, 32'h0));
        step(0, 8'h00);
        $display("seq reset: done");

        // Randomized traffic against the model.
        rst = 1'b0;
        step(0, 8'h00);
        model_reset();
        chk("rnd_init", m_exp());
        rst = 1'b1;
        pv = 90;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: pv = 95;
                    1: pv = 50;
                    default: pv = 10;
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                step(0, 8'h00);
                model_reset();
                chk("rnd_rst", m_exp());
                rst = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) < pv);
                b = 8'($urandom);
                step(v, b);
                model_step(v, b);
                chk($sformatf("rnd%0d", i), m_exp());
                if (m_vld || m_err)
                    $display("rnd %0d: vld=%b err=%b code=%h data=%h", i, cmd_valid, err_timeout,
                             cmd_code, cmd_data);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
